relu_pool_writer: RTL and testbench

RELU_POOL_WRITER -- requirements
Module: relu_pool_writer

---
 rtl/relu_pool_writer.sv | 158 +++++++++++++++
 tb/tb_relu_pool_writer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relu_pool_writer.sv
// ReLU + requantize + 2x2 max-pool over a streamed feature map, written to an output memory.
// Define RELU_POOL_ROUND_EN for round-half-up requantization; otherwise the shift truncates.
module relu_pool_writer #(
    parameter int unsigned IN_W       = 24,
    parameter int unsigned OUT_W      = 8,
    parameter int unsigned ROW_LEN    = 124,
    parameter int unsigned SHIFT      = 8,
    parameter int unsigned OUT_ADDR_W = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [IN_W-1:0]       in_data,
    input  logic                  in_done,
    output logic                  out_we,
    output logic [OUT_ADDR_W-1:0] out_addr,
    output logic [OUT_W-1:0]      out_data,
    output logic                  busy,
    output logic                  done
);
    localparam int unsigned COL_W = (ROW_LEN > 2) ? $clog2(ROW_LEN) : 1;
    localparam int unsigned HALF  = ROW_LEN / 2;
    localparam int unsigned IDX_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_LEN - 1);
    localparam logic [IN_W:0]    SAT_MAX  = (IN_W + 1)'((1 << OUT_W) - 1);

    typedef enum logic [1:0] {StIdle, StEvenRow, StOddRow, StDone} state_e;

    state_e                  state_q, state_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [OUT_W-1:0]        pair_q, pair_d;
    logic                    out_we_q, out_we_d;
    logic [OUT_ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic [OUT_W-1:0]        out_data_q, out_data_d;
    logic [OUT_W-1:0]        row_buf [HALF];

    logic                    accept;
    logic                    col_wrap;
    logic [IDX_W-1:0]        pair_idx;
    logic [IN_W:0]           mag;
    logic [IN_W:0]           shifted;
    logic [OUT_W-1:0]        q_val;
    logic [OUT_W-1:0]        pair_max;
    logic [OUT_W-1:0]        above;

    assign accept   = in_valid && (state_q == StEvenRow || state_q == StOddRow);
    assign col_wrap = (col_q == COL_LAST);
    assign pair_idx = IDX_W'(col_q >> 1);
    assign above    = row_buf[pair_idx];

    // One guard bit so the rounding add cannot wrap the largest positive input.
    always_comb begin
        mag = {1'b0, in_data};
`ifdef RELU_POOL_ROUND_EN
        mag = mag + ((IN_W + 1)'(1) << (SHIFT - 1));
`endif
        shifted = mag >> SHIFT;
        if (in_data[IN_W-1]) begin
            q_val = '0;
        end else if (shifted > SAT_MAX) begin
            q_val = '1;
        end else begin
            q_val = shifted[OUT_W-1:0];
        end
    end

    assign pair_max = (q_val > pair_q) ? q_val : pair_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (start) state_d = StEvenRow;
            StEvenRow: begin
                if (in_done) begin
                    state_d = StDone;
                end else if (accept && col_wrap) begin
                    state_d = StOddRow;
                end
            end
            StOddRow:  begin
                if (in_done) begin
                    state_d = StDone;
                end else if (accept && col_wrap) begin
                    state_d = StEvenRow;
                end
            end
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StDone);
    end

    always_comb begin
        col_d      = col_q;
        pair_d     = pair_q;
        out_we_d   = 1'b0;
        out_data_d = out_data_q;
        out_addr_d = out_addr_q;
        if (out_we_q) begin
            out_addr_d = out_addr_q + OUT_ADDR_W'(1);
        end
        if (state_q == StIdle && start) begin
            col_d      = '0;
            pair_d     = '0;
            out_addr_d = '0;
        end
        if (accept) begin
            col_d = col_wrap ? '0 : col_q + COL_W'(1);
            if (!col_q[0]) begin
                pair_d = q_val;
            end else if (state_q == StOddRow) begin
                out_we_d   = 1'b1;
                out_data_d = (pair_max > above) ? pair_max : above;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            pair_q     <= '0;
            out_we_q   <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
        end else begin
            col_q      <= col_d;
            pair_q     <= pair_d;
            out_we_q   <= out_we_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
        end
    end

    // Row buffer holds the even row's pair maxima; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (accept && col_q[0] && state_q == StEvenRow) begin
            row_buf[pair_idx] <= pair_max;
        end
    end

    assign out_we   = out_we_q;
    assign out_addr = out_addr_q;
    assign out_data = out_data_q;

endmodule

// File: tb/tb_relu_pool_writer.sv
// Self-checking bench for relu_pool_writer: fixed window vectors, corner sequences, random maps.
// Honours RELU_POOL_ROUND_EN in its reference model when the design is built with it.
module tb_relu_pool_writer;
    localparam int IN_W       = 24;
    localparam int OUT_W      = 8;
    localparam int ROW_LEN    = 4;
    localparam int SHIFT      = 8;
    localparam int OUT_ADDR_W = 4;
    localparam int MAXV       = (1 << OUT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic                  in_valid;
    logic [IN_W-1:0]       in_data;
    logic                  in_done;
    logic                  out_we;
    logic [OUT_ADDR_W-1:0] out_addr;
    logic [OUT_W-1:0]      out_data;
    logic                  busy;
    logic                  done;

    relu_pool_writer #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .ROW_LEN   (ROW_LEN),
        .SHIFT     (SHIFT),
        .OUT_ADDR_W(OUT_ADDR_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_done (in_done),
        .out_we  (out_we),
        .out_addr(out_addr),
        .out_data(out_data),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    typedef struct packed {
        logic [7:0][31:0] smp;  // smp[0..3] row 0, smp[4..7] row 1
        int               e0;
        int               e1;
    } vec_t;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    wr_t exp_q[$];
    wr_t obs_q[$];
    vec_t tbl[6];

    // Reference model: 0 idle, 1 running, 2 done cycle.
    int m_state = 0;
    int m_col, m_odd, m_addr;
    int m_even[ROW_LEN];
    int m_cur[ROW_LEN];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_we === 1'b1) obs_q.push_back('{int'(out_addr), int'(out_data), cyc});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int requant(input int v);
        longint r;
        if (v < 0) return 0;
        r = v;
`ifdef RELU_POOL_ROUND_EN
        r = r + (longint'(1) << (SHIFT - 1));
`endif
        r = r / (longint'(1) << SHIFT);
        return (r > MAXV) ? MAXV : int'(r);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3,
                                input int b0, input int b1, input int b2, input int b3,
                                input int e0, input int e1);
        vec_t v;
        v.smp = {b3, b2, b1, b0, a3, a2, a1, a0};
        v.e0  = e0;
        v.e1  = e1;
        return v;
    endfunction

    function automatic int rnd_data();
        case ($urandom_range(0, 3))
            0:       return -int'($urandom_range(1, 8388608));
            1:       return int'($urandom_range(0, 4095));
            2:       return int'($urandom_range(0, 131071));
            default: return int'($urandom_range(0, 32'h7FFFFF));
        endcase
    endfunction

    // Drive one cycle of inputs and advance the reference model over that cycle.
    task automatic send(input bit st, input bit v, input int d, input bit dn);
        int q, mx;
        @(posedge clk);
        #1;
        start    = st;
        in_valid = v;
        in_data  = d[IN_W-1:0];
        in_done  = dn;
        if (m_state == 0) begin
            if (st) begin
                m_state = 1;
                m_col   = 0;
                m_odd   = 0;
                m_addr  = 0;
            end
        end else if (m_state == 2) begin
            m_state = 0;
        end else begin
            if (v) begin
                q = requant(d);
                m_cur[m_col] = q;
                if (m_odd == 1 && (m_col % 2) == 1) begin
                    mx = max2(max2(m_even[m_col-1], m_even[m_col]),
                              max2(m_cur[m_col-1], m_cur[m_col]));
                    exp_q.push_back('{m_addr, mx, cyc + 1});
                    m_addr = (m_addr + 1) % (1 << OUT_ADDR_W);
                end
                m_col++;
                if (m_col == ROW_LEN) begin
                    m_col = 0;
                    if (m_odd == 0) m_even = m_cur;
                    m_odd = 1 - m_odd;
                end
            end
            if (dn) m_state = 2;
        end
    endtask

    task automatic finish_map(input bit v, input int d, input string nm);
        send(0, v, d, 1);
        send(0, 1, 12345, 0);
        chk({nm, " done pulse"}, int'(done), 1);
        chk({nm, " busy in done"}, int'(busy), 1);
        send(0, 0, 0, 0);
        chk({nm, " done low"}, int'(done), 0);
        chk({nm, " busy low"}, int'(busy), 0);
    endtask

    task automatic check_writes(input string nm);
        wr_t e, o;
        chk({nm, " write count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({nm, " addr"}, o.addr, e.addr);
            chk({nm, " data"}, o.data, e.data);
            chk({nm, " we cycle"}, o.cyc, e.cyc);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic run_vec(input vec_t v, input bit gap, input string nm);
        send(1, 0, 0, 0);
        for (int j = 0; j < 8; j++) begin
            send(0, 1, int'(v.smp[j]), 0);
            if (gap) send(0, 0, 0, 0);
        end
        finish_map(0, 0, nm);
        chk({nm, " table count"}, obs_q.size(), 2);
        if (obs_q.size() >= 2) begin
            chk({nm, " table addr0"}, obs_q[0].addr, 0);
            chk({nm, " table data0"}, obs_q[0].data, v.e0);
            chk({nm, " table addr1"}, obs_q[1].addr, 1);
            chk({nm, " table data1"}, obs_q[1].data, v.e1);
        end
        check_writes(nm);
    endtask

    initial begin
        int r0[4];
        int n, cnt, d;
        bit v, st;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_done  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_we", int'(out_we), 0);
        chk("reset out_addr", int'(out_addr), 0);
        chk("reset out_data", int'(out_data), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        rst_n = 1'b1;

        tbl[0] = mk(256, 512, 768, 1024, 0, -5, 2560, 256, 2, 10);
        tbl[1] = mk(0, 0, 0, 0, 32'h7FFFFF, 0, 0, 0, 255, 0);
        tbl[2] = mk(-1000, -1000, -1000, -1000, -1000, -1000, -1000, -1000, 0, 0);
`ifdef RELU_POOL_ROUND_EN
        tbl[3] = mk(384, 0, 0, 0, 0, 0, 0, 0, 2, 0);
        tbl[4] = mk(300, 1000, 65535, 70000, 511, -1, 25600, 256, 4, 255);
`else
        tbl[3] = mk(384, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[4] = mk(300, 1000, 65535, 70000, 511, -1, 25600, 256, 3, 255);
`endif
        tbl[5] = mk(65536, 255, 383, 0, 0, 0, 0, 0, 255, 1);

        // Valid while idle must be ignored.
        repeat (3) send(0, 1, 4096, 0);
        for (int i = 0; i < 6; i++) run_vec(tbl[i], 1'b0, $sformatf("vec%0d", i));
        run_vec(tbl[0], 1'b1, "toggle");

        // in_done after three samples of the odd row: only the completed pair is written.
        r0 = '{256, 512, 768, 1024};
        send(1, 0, 0, 0);
        for (int j = 0; j < 4; j++) send(0, 1, r0[j], 0);
        send(0, 1, 0, 0);
        send(0, 1, -5, 0);
        send(0, 1, 2560, 0);
        finish_map(0, 0, "partial");
        chk("partial count", obs_q.size(), 1);
        if (obs_q.size() >= 1) chk("partial data", obs_q[0].data, 2);
        check_writes("partial");

        // in_done together with the final sample: that sample's write still lands.
        send(1, 0, 0, 0);
        for (int j = 0; j < 4; j++) send(0, 1, r0[j], 0);
        send(0, 1, 0, 0);
        send(0, 1, -5, 0);
        send(0, 1, 2560, 0);
        finish_map(1, 256, "coincident");
        chk("coincident count", obs_q.size(), 2);
        if (obs_q.size() >= 2) chk("coincident data1", obs_q[1].data, 10);
        check_writes("coincident");

        // Asynchronous reset while a write is on the outputs.
        send(1, 0, 0, 0);
        for (int j = 0; j < 4; j++) send(0, 1, r0[j], 0);
        send(0, 1, 2560, 0);
        send(0, 1, 2560, 0);
        @(posedge clk);
        #2;
        chk("pre-reset out_we", int'(out_we), 1);
        chk("pre-reset out_data", int'(out_data), 10);
        rst_n = 1'b0;
        #1;
        chk("mid reset out_we", int'(out_we), 0);
        chk("mid reset out_addr", int'(out_addr), 0);
        chk("mid reset out_data", int'(out_data), 0);
        chk("mid reset busy", int'(busy), 0);
        chk("mid reset done", int'(done), 0);
        in_valid = 1'b0;
        m_state  = 0;
        exp_q.delete();
        obs_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) send(0, 1, 50000, 0);
        chk("post-reset writes", obs_q.size(), 0);
        chk("post-reset busy", int'(busy), 0);
        obs_q.delete();

        // Random maps with gaps, ignored starts and address wrap.
        for (int m = 0; m < 6; m++) begin
            send(1, 0, 0, 0);
            n   = (m == 0) ? ROW_LEN * 24 : int'($urandom_range(0, ROW_LEN * 24));
            cnt = 0;
            while (cnt < n) begin
                v  = ($urandom_range(0, 3) != 0);
                st = ($urandom_range(0, 15) == 0);
                d  = rnd_data();
                send(st, v, d, 0);
                if (v) cnt++;
            end
            if ($urandom_range(0, 1) == 1) finish_map(1, rnd_data(), "random");
            else finish_map(0, 0, "random");
            check_writes($sformatf("random%0d", m));
            repeat ($urandom_range(0, 3)) send(0, 1, rnd_data(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
